step_sequencer: RTL

//  Plays a looped pattern of up to STEPS stored notes at a programmable tempo.

---
 rtl/step_sequencer_pkg.sv | 14 +
 rtl/step_sequencer_ms_tick.sv | 30 +++
 rtl/step_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/step_sequencer_pkg.sv
// Shared types and timebase helpers for the step sequencer.
package step_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NOTE = 2'd1,
      GAP  = 2'd2
   } state_e;

   function automatic int cycles_per_ms(input int freq_hz);
      return freq_hz / 1000;
   endfunction

endpackage

// File: rtl/step_sequencer_ms_tick.sv
// Millisecond timebase: down-counter that reloads on wrap or restart.
module ms_tick_gen #(
   parameter int CYCLES_PER_MS = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CYCLES_PER_MS - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart || cnt_q == '0) cnt_d = RELOAD;
      else                        cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// Looped note pattern player: gated note phase then fixed silent gap per step.
module step_sequencer
   import step_sequencer_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int STEPS           = 16,
   parameter int NOTE_W          = 4,
   parameter int TEMPO_W         = 12,
   parameter int GAP_MS          = 10,
   localparam int SW             = $clog2(STEPS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               wr_en,
   input  logic [SW-1:0]      wr_addr,
   input  logic [NOTE_W-1:0]  wr_note,
   input  logic [TEMPO_W-1:0] tempo_ms,
   input  logic [SW-1:0]      last_step,
   output logic [NOTE_W-1:0]  note,
   output logic               gate,
   output logic               beat,
   output logic [SW-1:0]      step,
   output logic               busy
);

   localparam int CPM = cycles_per_ms(CLOCK_FREQUENCY);
   localparam logic [TEMPO_W-1:0] T_MIN    = TEMPO_W'(GAP_MS + 1);
   localparam logic [TEMPO_W-1:0] GAP_LAST = TEMPO_W'(GAP_MS - 1);

   state_e              state_q, state_d;
   logic [NOTE_W-1:0]   pat_q [STEPS];
   logic [NOTE_W-1:0]   pat_d [STEPS];
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [SW-1:0]       step_q, step_d;
   logic [TEMPO_W-1:0]  t_q, t_d;
   logic [TEMPO_W-1:0]  ms_cnt_q, ms_cnt_d;
   logic                gate_q, gate_d;
   logic                beat_q, beat_d;
   logic                busy_q, busy_d;
   logic                launch;
   logic [SW-1:0]       launch_step;
   logic [SW-1:0]       next_step;
   logic                ms_tick;

   ms_tick_gen #(.CYCLES_PER_MS(CPM)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (launch),
      .tick    (ms_tick)
   );

   always_comb begin
      state_d     = state_q;
      note_d      = note_q;
      step_d      = step_q;
      t_d         = t_q;
      ms_cnt_d    = ms_cnt_q;
      gate_d      = gate_q;
      beat_d      = 1'b0;
      launch      = 1'b0;
      launch_step = step_q;
      next_step   = (step_q >= last_step) ? '0 : step_q + SW'(1);
      for (int i = 0; i < STEPS; i++) pat_d[i] = pat_q[i];
      if (wr_en) pat_d[wr_addr] = wr_note;

      if (stop) begin
         state_d = IDLE;
         gate_d  = 1'b0;
      end else if (start) begin
         launch      = 1'b1;
         launch_step = '0;
      end else begin
         case (state_q)
            NOTE: if (ms_tick) begin
               if (ms_cnt_q == t_q - T_MIN) begin
                  state_d  = GAP;
                  gate_d   = 1'b0;
                  ms_cnt_d = '0;
               end else begin
                  ms_cnt_d = ms_cnt_q + TEMPO_W'(1);
               end
            end
            GAP: if (ms_tick) begin
               if (ms_cnt_q == GAP_LAST) begin
                  launch      = 1'b1;
                  launch_step = next_step;
               end else begin
                  ms_cnt_d = ms_cnt_q + TEMPO_W'(1);
               end
            end
            default: ;
         endcase
      end

      // Step start: note is latched so later writes only hit the next visit
      if (launch) begin
         state_d  = NOTE;
         step_d   = launch_step;
         note_d   = pat_q[launch_step];
         gate_d   = (pat_q[launch_step] != '0);
         beat_d   = 1'b1;
         ms_cnt_d = '0;
         t_d      = (tempo_ms > T_MIN) ? tempo_ms : T_MIN;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         note_q   <= '0;
         step_q   <= '0;
         t_q      <= '0;
         ms_cnt_q <= '0;
         gate_q   <= 1'b0;
         beat_q   <= 1'b0;
         busy_q   <= 1'b0;
         for (int i = 0; i < STEPS; i++) pat_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         note_q   <= note_d;
         step_q   <= step_d;
         t_q      <= t_d;
         ms_cnt_q <= ms_cnt_d;
         gate_q   <= gate_d;
         beat_q   <= beat_d;
         busy_q   <= busy_d;
         pat_q    <= pat_d;
      end
   end

   assign note = note_q;
   assign gate = gate_q;
   assign beat = beat_q;
   assign step = step_q;
   assign busy = busy_q;

endmodule
